// File: rtl/console_tx_if.sv
// Signal bundle between the CPU output trap and the serial console transmitter.
// master = CPU/trap side, slave = console_tx.
interface console_tx_if;
    logic        print;
    logic [15:0] data;
    logic        tx;
    logic        busy;
    logic        full;
    logic        overflow;

    modport master (
        output print,
        output data,
        input  tx,
        input  busy,
        input  full,
        input  overflow
    );

    modport slave (
        input  print,
        input  data,
        output tx,
        output busy,
        output full,
        output overflow
    );
endinterface

// File: rtl/console_tx.sv
// Console serial transmitter: buffers characters from the CPU print trap in a FIFO and sends
// them as 8N1 frames. Optional even-parity bit when CONSOLE_TX_PARITY_EN is defined (8E1).
module console_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input logic         clock,
    input logic         reset_n,
    console_tx_if.slave con
);
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

`ifdef CONSOLE_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            overflow_q;
`ifdef CONSOLE_TX_PARITY_EN
    logic            parity_q;
`endif

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic baud_done;
    logic unused_data_hi;

    assign fifo_full  = (count_q == CntFull);
    assign fifo_empty = (count_q == '0);
    assign push       = con.print & ~fifo_full;
    assign pop        = (state_q == StIdle) & ~fifo_empty;
    assign baud_done  = (baud_q == BaudLast);

    // Only the low byte of R0 is a character.
    assign unused_data_hi = ^con.data[15:8];

    // Storage has no reset; resetting the pointers is what discards the contents.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= con.data[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            // A strobe while full is lost even if a pop frees a slot this cycle.
            if (con.print && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef CONSOLE_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            baud_q <= baud_done ? '0 : baud_q + BaudW'(1);
            case (state_q)
                StIdle: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q  <= mem_q[rd_ptr_q];
`ifdef CONSOLE_TX_PARITY_EN
                        parity_q <= ^mem_q[rd_ptr_q];
`endif
                        bit_q    <= '0;
                        tx_q     <= 1'b0;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    if (baud_done) begin
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (baud_done) begin
                        if (bit_q == 3'd7) begin
`ifdef CONSOLE_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end
                end
`ifdef CONSOLE_TX_PARITY_EN
                StParity: begin
                    if (baud_done) begin
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (baud_done) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign con.tx       = tx_q;
    assign con.busy     = ~fifo_empty | (state_q != StIdle);
    assign con.full     = fifo_full;
    assign con.overflow = overflow_q;

endmodule

// File: tb/tb_console_tx.sv
// Scoreboard bench for console_tx: stimulus queues expected characters with their frame start
// cycles; a serial monitor decodes tx and checks each frame against the queue head.
`timescale 1ns/1ps
module tb_console_tx;
    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 8;
`ifdef CONSOLE_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam int NO_PREV = -100000;

    typedef struct {
        logic [7:0] ch;
        int         start;
    } exp_t;

    exp_t exp_q[$];

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic tx_prev = 1'b1;
    int   cyc     = 0;
    int   epoch   = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   prev_start = NO_PREV;

    console_tx_if con ();

    console_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .con    (con)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge reset_n) epoch = epoch + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one strobe at the next edge; t returns the edge number at which it is sampled.
    task automatic strobe(input logic [15:0] d, input bit expect_sent, output int t);
        exp_t e;
        @(negedge clock);
        con.print = 1'b1;
        con.data  = d;
        t = cyc + 1;
        if (expect_sent) begin
            e.ch    = d[7:0];
            e.start = (t + 1 > prev_start + FRAME + 1) ? t + 1 : prev_start + FRAME + 1;
            prev_start = e.start;
            exp_q.push_back(e);
        end
    endtask

    task automatic end_strobes();
        @(negedge clock);
        con.print = 1'b0;
        con.data  = 16'h0000;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 12 * FRAME) begin
            @(negedge clock);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (CPB) @(negedge clock);
    endtask

    task automatic decode_frame();
        int               ep = epoch;
        int               st = cyc;
        logic [NBITS-1:0] bits;
        exp_t             e;
        repeat (CPB / 2) @(negedge clock);
        bits[0] = con.tx;
        for (int i = 1; i < NBITS; i++) begin
            repeat (CPB) @(negedge clock);
            bits[i] = con.tx;
        end
        if (ep != epoch) return;  // frame cut short by reset; nothing was expected
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_frame: got byte 0x%0h starting at cycle %0d, expected none",
                     bits[8:1], st);
            return;
        end
        e = exp_q.pop_front();
        check("start_bit", bits[0], 1'b0);
        check("data_byte", bits[8:1], e.ch);
        check("start_cycle", st, e.start);
`ifdef CONSOLE_TX_PARITY_EN
        check("parity_bit", bits[9], ^e.ch);
`endif
        check("stop_bit", bits[NBITS-1], 1'b1);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset_n && tx_prev && !con.tx) begin
                decode_frame();
            end
            tx_prev = con.tx;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t;
        int e0;
        int quiet_bad;
        con.print = 1'b0;
        con.data  = 16'h0000;

        #1 reset_n = 1'b0;
        #1;
        check("rst_tx", con.tx, 1'b1);
        check("rst_busy", con.busy, 1'b0);
        check("rst_full", con.full, 1'b0);
        check("rst_overflow", con.overflow, 1'b0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("idle_tx", con.tx, 1'b1);

        // Single 'A' with busy timing relative to the strobe edge.
        strobe(16'h0041, 1'b1, t);
        end_strobes();
        check("busy_after_strobe", con.busy, 1'b1);
        while (cyc < t + FRAME) @(negedge clock);
        check("busy_last_cycle", con.busy, 1'b1);
        @(negedge clock);
        check("busy_drop", con.busy, 1'b0);
        check("tx_idle_after_frame", con.tx, 1'b1);
        wait_drain("drain_single");

        // Burst "Hi!" back to back.
        strobe(16'h0048, 1'b1, t);
        strobe(16'h0069, 1'b1, t);
        strobe(16'h0021, 1'b1, t);
        end_strobes();
        wait_drain("drain_burst");
        check("burst_overflow", con.overflow, 1'b0);

        // Upper byte ignored; then the two parity vectors.
        strobe(16'hFF30, 1'b1, t);
        end_strobes();
        wait_drain("drain_upper");
        strobe(16'h0007, 1'b1, t);
        strobe(16'h0003, 1'b1, t);
        end_strobes();
        wait_drain("drain_parity");

        // Ten strobes in ten cycles: one popped, eight buffered, tenth dropped.
        e0 = 0;
        for (int k = 0; k < 10; k++) begin
            strobe(16'h0030 + 16'(k), k < 9, t);
            if (k == 0) e0 = t;
            if (k == 8) check("full_before_8th", con.full, 1'b0);
            if (k == 9) begin
                check("full_at_8", con.full, 1'b1);
                check("ovf_before_drop", con.overflow, 1'b0);
            end
        end
        end_strobes();
        check("ovf_cycle", cyc - e0, 9);
        check("full_after_drop", con.full, 1'b1);
        check("ovf_after_drop", con.overflow, 1'b1);
        wait_drain("drain_overflow");
        check("ovf_sticky", con.overflow, 1'b1);
        check("full_cleared", con.full, 1'b0);

        // Reset in the middle of data bit 3 of 0xF0 (a low bit).
        strobe(16'h00F0, 1'b0, t);
        end_strobes();
        while (cyc < t + 1 + 4 * CPB + CPB / 2) @(negedge clock);
        check("mid_bit3_low", con.tx, 1'b0);
        check("mid_busy", con.busy, 1'b1);
        check("mid_ovf_sticky", con.overflow, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_tx", con.tx, 1'b1);
        check("abort_busy", con.busy, 1'b0);
        check("abort_overflow", con.overflow, 1'b0);
        check("abort_full", con.full, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        prev_start = NO_PREV;
        quiet_bad = 0;
        repeat (300) begin
            @(negedge clock);
            if (con.tx !== 1'b1 || con.busy !== 1'b0) quiet_bad++;
        end
        check("quiet_after_reset", quiet_bad, 0);

        // Transmitter still works after the abort.
        strobe(16'h005A, 1'b1, t);
        end_strobes();
        wait_drain("drain_after_reset");
        check("final_busy", con.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/console_tx.md
CONSOLE_TX -- requirements
Module: console_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 16: number of clock cycles per serial bit, minimum 2.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 8: number of character entries, a power of two, minimum 2.
REQ-003 The module SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 Port: clock  input  1  rising-edge system clock, the same clock as the CPU core.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: print  input  1  single-cycle strobe from the CPU output trap; means "emit character".
REQ-007 Port: data  input  16  R0 value sampled with print; only bits [7:0] are transmitted.
REQ-008 Port: tx  output  1  serial line; idles high.
REQ-009 Port: busy  output  1  high while the FIFO is non-empty or a frame is in flight.
REQ-010 Port: full  output  1  high when the FIFO holds FIFO_DEPTH entries.
REQ-011 Port: overflow  output  1  sticky flag: a strobe arrived while full.

Function
REQ-012 The module SHALL write data[7:0] into the FIFO on a rising edge where print=1 and full=0.
REQ-013 A strobe (print=1) while full=1 SHALL be dropped, and overflow SHALL be set. This applies even if a pop occurs in the same cycle.
REQ-014 The FSM SHALL use these states: IDLE, START, DATA, PARITY (macro builds only), STOP.
REQ-015 IDLE: when the FIFO is non-empty, the FSM SHALL pop the head into the shift register, clear the bit counter, and go to START.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA: tx SHALL drive bits LSB first, each for CLKS_PER_BIT cycles. After bit 7 it SHALL go to PARITY or STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 A new character SHALL NOT start inside a frame; back-to-back frames SHALL have exactly one IDLE cycle between the STOP and the next START.
REQ-020 Latency: a strobe written at edge E SHALL be popped at edge E+1, and tx SHALL go low after edge E+1 when the FSM was idle.
REQ-021 The baud counter SHALL count 0 to CLKS_PER_BIT-1, wrap to 0, and reset to 0 on every state change.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH. The count SHALL stay unchanged on a simultaneous push and pop.
REQ-023 busy SHALL be asserted whenever the count is non-zero or the state is not IDLE.

Reset
REQ-024 While reset_n=0, asynchronously: state=IDLE, tx=1, busy=0, full=0, overflow=0, and FIFO pointers, count and counters all 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately with tx=1. All FIFO contents SHALL be discarded.
REQ-026 After reset_n deasserts, no frame SHALL start until a new print write.

Configuration
REQ-027 Macro CONSOLE_TX_PARITY_EN SHALL control the parity bit.
- When defined: after DATA, the FSM SHALL enter PARITY and drive tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then STOP. Frame = 11 bits.
- When undefined: the PARITY state and its logic SHALL not exist, and DATA SHALL go directly to STOP. Frame = 10 bits.

Verification
REQ-028 Single character, CLKS_PER_BIT=16, no macro: print with data=16'h0041 -> tx shows 0, 1,0,0,0,0,0,1,0, 1, each bit 16 cycles; busy is low 160 cycles after the frame starts, plus 1 cycle.
REQ-029 Burst: 3 consecutive strobes with 'H','i','!' -> three frames in order, one IDLE cycle between each, overflow=0.
REQ-030 Overflow, FIFO_DEPTH=8: 10 strobes in 10 consecutive cycles -> 9 characters sent (1 popped plus 8 buffered), the 10th is dropped, full=1 observed, and overflow=1 stays high until reset.
REQ-031 Reset mid-frame: reset_n=0 during DATA bit 3 -> tx=1 within the same cycle, busy=0; after release, tx stays high with no print.
REQ-032 Parity, with CONSOLE_TX_PARITY_EN: data=8'h07 -> parity bit 1; data=8'h03 -> parity bit 0; frame length 176 cycles.
REQ-033 Upper-byte ignore: data=16'hFF30 -> the transmitted byte is 8'h30.
